int_to_fp_scheduler: RTL and testbench
======================================

# int_to_fp_scheduler

Round-robin scheduler that shares one combinational int32-to-float32 converter between NREQ requesters. It wraps the converter in a two-entry pipeline (operand register, result register) with per-requester accept pulses and a valid/ready result port that returns the requester tag. It sits between integer producers (ALU lanes, DMA unpackers) and any float consumer that needs one conversion per cycle.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- TW, 2, tag width; must satisfy 2**TW >= NREQ.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  bit i set: requester i has an operand pending.
- data  in  32*NREQ  operand of requester i on data[32*i+31:32*i], two's complement.
- ack  out  NREQ  one-hot accept strobe; operand i is captured on the edge ending a cycle with ack[i]=1.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result on an edge with out_valid & out_ready.
- out_fp  out  32  IEEE-754 single result.
- out_p_lost  out  1  1 when nonzero bits were truncated.
- out_tag  out  TW  index of the requester that issued the operand.

## Operation
- Stage A (operand register): a_valid, a_data, a_tag. Stage B (result register): out_valid, out_fp, out_p_lost, out_tag.
- Stage B load enable is ld_b = !out_valid | out_ready. Stage A can accept when ld_a = !a_valid | ld_b.
- Arbiter: when ld_a=1 and req is nonzero, grant the first set req bit searching from (last+1) mod NREQ upward with wrap. Drive ack[g]=1 combinationally in that cycle. Capture data[g] and tag g into A. Set last=g.
- When ld_a=0, ack=0 and last does not change. While rst=1, ack=0.
- Requesters hold req and data stable until they see ack. Deasserting req before ack is allowed; the request is simply not granted.
- On ld_b, B loads conv(A) with out_valid=a_valid. If ld_a and no grant occurs, a_valid clears.
- Converter, conv(d):
  - sign = d[31]; mag = sign ? -d : d (32-bit).
  - Normalise mag by left shift s (0..31) until bit 31 is 1.
  - fraction = norm[30:8]; exponent = 158 - s (8 bits).
  - p_lost = |norm[7:0]. Truncation only, no rounding.
  - d=0 gives out_fp=0x00000000 with p_lost=0.
  - d=0x80000000 gives 0xCF000000 (mag stays 0x80000000, s=0).
- States are implicit in (a_valid, out_valid): EMPTY (0,0), ONE (1,0) or (0,1), FULL (1,1).
  - FULL with out_ready=0: no ack; both registers hold.
  - FULL with out_ready=1: pass-through; one accept and one retire in the same cycle.

## Timing
- Reset values: a_valid=0, out_valid=0, out_fp=0, out_p_lost=0, out_tag=0, last=NREQ-1 (so requester 0 wins first), ack=0.
- Asserting rst mid-operation discards in-flight results immediately. Requesters that were acked lose their operand.
- Latency: ack in cycle 0, A valid in cycle 1, out_valid in cycle 2 (two edges from accept to result), given out_ready=1.
- Throughput: one conversion per cycle while requests exist and out_ready=1.
- Capacity: two operands maximum in flight. With out_ready=0 from EMPTY, two acks are issued, then ack stays 0 until the consumer retires a result.
- Output stability: out_fp, out_p_lost and out_tag are unchanged while out_valid=1 and out_ready=0.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Retire-and-accept in the same cycle is always allowed in FULL.

## Test plan
- Single request: req=0001, data0=1 → ack=0001 for one cycle; 2 cycles later out_valid=1, out_fp=0x3F800000, p_lost=0, tag=0. Then data0=-1 → 0xBF800000.
- Boundary values through requester 2: 0 → 0x00000000/p_lost 0; 0x7FFFFFFF → 0x4EFFFFFF/p_lost 1; 0x80000000 → 0xCF000000/p_lost 0; 0x01000001 → 0x4B800000/p_lost 1. All carry tag 2.
- Round-robin: all req held high with out_ready=1 for 8 cycles → ack sequence 0,1,2,3,0,1,2,3; outputs back-to-back with matching tags; no bubbles.
- Backpressure: out_ready=0, all requesting → exactly 2 acks, then none. out_fp is held for 5 cycles. After raising out_ready, one retire per cycle; the next grant goes to requester 2.
- Request withdrawal: req1 pulsed for a cycle while FULL and stalled → no ack[1]; nothing from requester 1 appears.
- Reset mid-flight: assert rst asynchronously between edges with FULL → out_valid and ack drop at once. After release, req=1000 is granted first-pass as requester 3 (pointer reset); the output has tag 3.

Source files
------------

// File: rtl/int_to_fp_scheduler.sv
// Round-robin scheduler sharing one int32-to-float32 converter between NREQ requesters.
// Two-entry pipeline: operand register (stage A) feeding a result register (stage B).
module int_to_fp_scheduler #(
  parameter int NREQ = 4,
  parameter int TW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [32*NREQ-1:0] data,
  output logic [NREQ-1:0]   ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_fp,
  output logic              out_p_lost,
  output logic [TW-1:0]     out_tag
);

  // Truncating int32 -> float32; result is {p_lost, fp}. Zero input leaves norm[31] clear.
  function automatic logic [32:0] conv(input logic [31:0] d);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  s;
    logic [7:0]  expo;
    logic [32:0] res;
    sign = d[31];
    mag  = sign ? (32'd0 - d) : d;
    s    = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) s = 5'(31 - i);
      else        s = s;
    end
    norm = mag << s;
    expo = 8'd158 - {3'b000, s};
    if (norm[31] == 1'b0) res = 33'd0;
    else                  res = {|norm[7:0], sign, expo, norm[30:8]};
    return res;
  endfunction

  logic              a_valid_r;
  logic [31:0]       a_data_r;
  logic [TW-1:0]     a_tag_r;
  logic [TW-1:0]     last_r;
  logic              out_valid_r;
  logic [31:0]       out_fp_r;
  logic              out_p_lost_r;
  logic [TW-1:0]     out_tag_r;

  logic              ld_a_s;
  logic              ld_b_s;
  logic              grant_s;
  logic [TW-1:0]     gidx_s;
  int                idx_s;
  logic [NREQ-1:0]   ack_s;
  logic [32:0]       conv_s;

  assign ld_b_s = !out_valid_r | out_ready;
  assign ld_a_s = !a_valid_r | ld_b_s;
  assign conv_s = conv(a_data_r);

  // First set request searching upward from the slot after the last grant, with wrap.
  always_comb begin
    grant_s = 1'b0;
    gidx_s  = '0;
    idx_s   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = (int'(last_r) + k) % NREQ;
      if (!grant_s && req[idx_s]) begin
        grant_s = 1'b1;
        gidx_s  = TW'(idx_s);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // One-hot accept strobe, suppressed during reset and while stage A is blocked.
  always_comb begin
    ack_s = '0;
    if (!rst && ld_a_s && grant_s) ack_s[gidx_s] = 1'b1;
    else                           ack_s = '0;
  end

  // Pipeline registers and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_r    <= 1'b0;
      a_data_r     <= 32'd0;
      a_tag_r      <= '0;
      last_r       <= TW'(NREQ - 1);
      out_valid_r  <= 1'b0;
      out_fp_r     <= 32'd0;
      out_p_lost_r <= 1'b0;
      out_tag_r    <= '0;
    end else begin
      if (ld_a_s) begin
        a_valid_r <= grant_s;
        if (grant_s) begin
          a_data_r <= data[32*int'(gidx_s) +: 32];
          a_tag_r  <= gidx_s;
          last_r   <= gidx_s;
        end
      end
      if (ld_b_s) begin
        out_valid_r  <= a_valid_r;
        out_fp_r     <= conv_s[31:0];
        out_p_lost_r <= conv_s[32];
        out_tag_r    <= a_tag_r;
      end
    end
  end

  assign ack        = ack_s;
  assign out_valid  = out_valid_r;
  assign out_fp     = out_fp_r;
  assign out_p_lost = out_p_lost_r;
  assign out_tag    = out_tag_r;

endmodule

// File: tb/tb_int_to_fp_scheduler.sv
// Directed self-checking bench for int_to_fp_scheduler (NREQ=4, TW=2).
module tb_int_to_fp_scheduler;

  localparam int NREQ = 4;
  localparam int TW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [32*NREQ-1:0] data;
  logic [NREQ-1:0]   ack;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_fp;
  logic              out_p_lost;
  logic [TW-1:0]     out_tag;

  int total = 0;
  int bad   = 0;

  int_to_fp_scheduler #(.NREQ(NREQ), .TW(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_fp(out_fp),
    .out_p_lost(out_p_lost), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; data = '0; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; data = '0; out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_fp !== 32'h0) begin bad++; $display("FAIL reset_fp: got %h want 00000000", out_fp); end
    total++; if (out_p_lost !== 1'b0) begin bad++; $display("FAIL reset_plost: got %b want 0", out_p_lost); end
    total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
    req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [31:0] vin  [2];
    logic [31:0] vexp [2];
    vin[0] = 32'd1;         vexp[0] = 32'h3F800000;
    vin[1] = 32'hFFFFFFFF;  vexp[1] = 32'hBF800000;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      req = 4'b0001; data[31:0] = vin[n];
      #1;
      total++; if (ack !== 4'b0001) begin bad++; $display("FAIL single_ack%0d: got %b want 0001", n, ack); end
      tick();
      req = 4'b0000;
      #1;
      total++; if (ack !== 4'b0000 || out_valid !== 1'b0) begin bad++; $display("FAIL single_mid%0d: got ack=%b v=%b want 0000/0", n, ack, out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid%0d: got %b want 1", n, out_valid); end
      total++; if (out_fp !== vexp[n]) begin bad++; $display("FAIL single_fp%0d: got %h want %h", n, out_fp, vexp[n]); end
      total++; if (out_p_lost !== 1'b0 || out_tag !== 2'd0) begin bad++; $display("FAIL single_tag%0d: got lost=%b tag=%0d want 0/0", n, out_p_lost, out_tag); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_retire%0d: got %b want 0", n, out_valid); end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] vin  [4];
    logic [31:0] vexp [4];
    logic        lexp [4];
    vin[0] = 32'h00000000; vexp[0] = 32'h00000000; lexp[0] = 1'b0;
    vin[1] = 32'h7FFFFFFF; vexp[1] = 32'h4EFFFFFF; lexp[1] = 1'b1;
    vin[2] = 32'h80000000; vexp[2] = 32'hCF000000; lexp[2] = 1'b0;
    vin[3] = 32'h01000001; vexp[3] = 32'h4B800000; lexp[3] = 1'b1;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      req = 4'b0100; data[95:64] = vin[n];
      #1;
      total++; if (ack !== 4'b0100) begin bad++; $display("FAIL bound_ack%0d: got %b want 0100", n, ack); end
      tick();
      req = 4'b0000;
      tick();
      total++; if (out_valid !== 1'b1 || out_fp !== vexp[n]) begin bad++; $display("FAIL bound_fp%0d: got v=%b %h want 1 %h", n, out_valid, out_fp, vexp[n]); end
      total++; if (out_p_lost !== lexp[n] || out_tag !== 2'd2) begin bad++; $display("FAIL bound_tag%0d: got lost=%b tag=%0d want %b/2", n, out_p_lost, out_tag, lexp[n]); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] fexp [4];
    fexp[0] = 32'h3F800000; fexp[1] = 32'h40000000; fexp[2] = 32'h40400000; fexp[3] = 32'h40800000;
    do_reset();
    for (int i = 0; i < NREQ; i++) data[32*i +: 32] = 32'(i + 1);
    req = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req = 4'b0000;
      #1;
      if (c < 8) begin
        total++; if (ack !== 4'(1 << (c % 4))) begin bad++; $display("FAIL rr_ack%0d: got %b want %b", c, ack, 4'(1 << (c % 4))); end
      end else begin
        total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rr_idle%0d: got %b want 0000", c, ack); end
      end
      if (c >= 2) begin
        total++; if (out_valid !== 1'b1 || out_tag !== 2'((c - 2) % 4)) begin bad++; $display("FAIL rr_out%0d: got v=%b tag=%0d want 1/%0d", c, out_valid, out_tag, (c - 2) % 4); end
        total++; if (out_fp !== fexp[(c - 2) % 4]) begin bad++; $display("FAIL rr_fp%0d: got %h want %h", c, out_fp, fexp[(c - 2) % 4]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int nack;
    do_reset();
    for (int i = 0; i < NREQ; i++) data[32*i +: 32] = 32'(i + 1);
    out_ready = 1'b0;
    req = 4'b1111;
    nack = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (ack != 4'b0000) nack++;
      if (c >= 2) begin
        total++; if (out_valid !== 1'b1 || out_fp !== 32'h3F800000 || out_tag !== 2'd0) begin bad++; $display("FAIL bp_hold%0d: got v=%b %h tag=%0d want 1 3f800000 0", c, out_valid, out_fp, out_tag); end
      end
      tick();
    end
    total++; if (nack != 2) begin bad++; $display("FAIL bp_acks: got %0d want 2", nack); end
    out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0100) begin bad++; $display("FAIL bp_next: got %b want 0100", ack); end
    total++; if (out_tag !== 2'd0) begin bad++; $display("FAIL bp_ret0: got tag=%0d want 0", out_tag); end
    tick();
    total++; if (ack !== 4'b1000 || out_tag !== 2'd1 || out_fp !== 32'h40000000) begin bad++; $display("FAIL bp_ret1: got ack=%b tag=%0d %h want 1000 1 40000000", ack, out_tag, out_fp); end
    tick();
    req = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_fp !== 32'h40400000) begin bad++; $display("FAIL bp_ret2: got v=%b tag=%0d %h want 1 2 40400000", out_valid, out_tag, out_fp); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd3 || out_fp !== 32'h40800000) begin bad++; $display("FAIL bp_ret3: got v=%b tag=%0d %h want 1 3 40800000", out_valid, out_tag, out_fp); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_withdraw();
    do_reset();
    out_ready = 1'b0;
    req = 4'b0001; data[31:0] = 32'd5; data[63:32] = 32'd9;
    #1;
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wd_ack0: got %b want 0001", ack); end
    tick();
    data[31:0] = 32'd6;
    #1;
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL wd_ack1: got %b want 0001", ack); end
    tick();
    req = 4'b0010;
    #1;
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL wd_pulse: got %b want 0000", ack); end
    tick();
    req = 4'b0000;
    out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_fp !== 32'h40A00000) begin bad++; $display("FAIL wd_out0: got v=%b tag=%0d %h want 1 0 40a00000", out_valid, out_tag, out_fp); end
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_fp !== 32'h40C00000) begin bad++; $display("FAIL wd_out1: got v=%b tag=%0d %h want 1 0 40c00000", out_valid, out_tag, out_fp); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wd_none0: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wd_none1: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < NREQ; i++) data[32*i +: 32] = 32'(i + 1);
    out_ready = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rm_full: got %b want 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", out_valid); end
    total++; if (ack !== 4'b0000) begin bad++; $display("FAIL rm_ack: got %b want 0000", ack); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    req = 4'b1000; data[127:96] = 32'd7;
    #1;
    total++; if (ack !== 4'b1000) begin bad++; $display("FAIL rm_grant: got %b want 1000", ack); end
    tick();
    req = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b1 || out_tag !== 2'd3 || out_fp !== 32'h40E00000) begin bad++; $display("FAIL rm_out: got v=%b tag=%0d %h want 1 3 40e00000", out_valid, out_tag, out_fp); end
  endtask

  initial begin
    rst = 1'b1; req = '0; data = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_boundary();
    test_round_robin();
    test_backpressure();
    test_withdraw();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
